// File: rtl/sipo_pkg.sv
// Shared definitions for the serial shift-register link (sipo_rx receiver, piso transmitter).
package sipo_pkg;

  // Default word width used by both ends of the link.
  localparam int SIPO_WIDTH = 4;

  // Receiver framing state.
  typedef enum logic {
    SIPO_IDLE  = 1'b0,
    SIPO_SHIFT = 1'b1
  } sipo_state_t;

endpackage

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out word receiver.
// Assembles framed serial bits into WIDTH-bit words. Each finished word goes into a
// valid/ready holding register. Sticky flags report dropped words and restarts mid-word.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdi,
  input  logic             bit_en,
  input  logic             start,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);

  sipo_state_t      r_state;
  sipo_state_t      w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [CW-1:0]    w_cnt_after;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] w_shift_sr;
  logic [WIDTH-1:0] w_fresh_sr;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_overrun;
  logic             r_frame_err;
  logic             w_complete;
  logic             w_frame_set;
  logic             w_overrun_set;
  logic             w_load;

  // Shift direction. A fresh word starts with only the current bit in place, so no stale
  // bits from an aborted word can leak into the next one.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shift_sr = sdi;
      assign w_fresh_sr = sdi;
    end else if (MSB_FIRST) begin : g_msb
      assign w_shift_sr = {r_sr[WIDTH-2:0], sdi};
      assign w_fresh_sr = {{(WIDTH-1){1'b0}}, sdi};
    end else begin : g_lsb
      assign w_shift_sr = {sdi, r_sr[WIDTH-1:1]};
      assign w_fresh_sr = {sdi, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // Next-state logic: consume qualified bits, detect word completion and restarts mid-word.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cnt_after  = r_cnt;
    w_sr_next    = r_sr;
    w_complete   = 1'b0;
    w_frame_set  = 1'b0;
    if (bit_en && (start || (r_state == SIPO_SHIFT))) begin
      if (start) begin
        w_sr_next   = w_fresh_sr;
        w_cnt_after = CNT_ONE;
        w_frame_set = (r_state == SIPO_SHIFT);
      end else begin
        w_sr_next   = w_shift_sr;
        w_cnt_after = r_cnt + CNT_ONE;
      end
      if (w_cnt_after == CNT_FULL) begin
        w_complete   = 1'b1;
        w_state_next = SIPO_IDLE;
        w_cnt_next   = '0;
      end else begin
        w_state_next = SIPO_SHIFT;
        w_cnt_next   = w_cnt_after;
      end
    end
  end

  // A finished word is taken if the holding register is free or is being drained this edge.
  assign w_load        = w_complete && (!r_q_valid || q_ready);
  assign w_overrun_set = w_complete && r_q_valid && !q_ready;

  // Framing state, bit counter and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SIPO_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sr    <= w_sr_next;
    end
  end

  // Output holding register with valid/ready handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_load) begin
      r_q       <= w_sr_next;
      r_q_valid <= 1'b1;
    end else if (r_q_valid && q_ready) begin
      r_q_valid <= 1'b0;
    end
  end

  // Sticky error flags. A set event on the same edge as a clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_overrun_set)  r_overrun <= 1'b1;
      else if (clr_flags) r_overrun <= 1'b0;
      if (w_frame_set)    r_frame_err <= 1'b1;
      else if (clr_flags) r_frame_err <= 1'b0;
    end
  end

  assign q         = r_q;
  assign q_valid   = r_q_valid;
  assign busy      = (r_state == SIPO_SHIFT);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule
